// File: rtl/inst_mem_loadable.sv
// Loadable instruction memory: a byte-serial boot loader fills it, then it serves
// single-cycle-latency fetches with stall hold; unloaded addresses read as NOP_WORD.
module inst_mem_loadable #(
  parameter int unsigned ADDR_W   = 6,
  parameter int unsigned DATA_W   = 32,
  parameter logic [DATA_W-1:0] NOP_WORD = '0
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              load_valid_i,
  input  logic [7:0]        load_byte_i,
  input  logic              load_last_i,
  output logic              load_ready_o,
  output logic              load_done_o,
  input  logic              reload_i,
  input  logic              fetch_req_i,
  input  logic [ADDR_W-1:0] fetch_addr_i,
  input  logic              fetch_stall_i,
  output logic              inst_valid_o,
  output logic [DATA_W-1:0] inst_out_o,
  output logic [ADDR_W-1:0] inst_addr_o,
  output logic [ADDR_W:0]   word_cnt_o
);

  localparam int unsigned BYTES  = DATA_W / 8;
  localparam int unsigned BIDX_W = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam int unsigned DEPTH  = 1 << ADDR_W;
  localparam logic [BIDX_W-1:0] LastIdx = BIDX_W'(BYTES - 1);
  localparam logic [ADDR_W:0]   Full    = (ADDR_W + 1)'(DEPTH);

  typedef enum logic [0:0] {StLoad, StRun} state_e;

  state_e              state_q;
  logic [ADDR_W-1:0]   wr_addr_q;
  logic [BIDX_W-1:0]   byte_idx_q;
  logic [DATA_W-1:0]   asm_q;
  logic [ADDR_W:0]     word_cnt_q;
  logic                inst_valid_q;
  logic [DATA_W-1:0]   inst_out_q;
  logic [ADDR_W-1:0]   inst_addr_q;

  logic [DATA_W-1:0]   mem_q [DEPTH];
  logic [DATA_W-1:0]   asm_word;
  logic                accept;
  logic                commit;
  logic                hit;

  // Current byte merged into its lane; upper lanes remain zero for a short last word.
  always_comb begin
    asm_word = asm_q;
    for (int unsigned i = 0; i < BYTES; i++) begin
      if (BIDX_W'(i) == byte_idx_q) begin
        asm_word[8*i +: 8] = load_byte_i;
      end
    end
  end

  assign accept = (state_q == StLoad) && load_valid_i;
  assign commit = accept && ((byte_idx_q == LastIdx) || load_last_i);
  assign hit    = ({1'b0, fetch_addr_i} < word_cnt_q);

  // Storage is deliberately not reset; word_cnt alone decides what is valid.
  always_ff @(posedge clk_i) begin
    if (commit) begin
      mem_q[wr_addr_q] <= asm_word;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= StLoad;
      wr_addr_q    <= '0;
      byte_idx_q   <= '0;
      asm_q        <= '0;
      word_cnt_q   <= '0;
      inst_valid_q <= 1'b0;
      inst_out_q   <= NOP_WORD;
      inst_addr_q  <= '0;
    end else begin
      unique case (state_q)
        StLoad: begin
          if (commit) begin
            word_cnt_q <= word_cnt_q + 1'b1;
            byte_idx_q <= '0;
            asm_q      <= '0;
            if (word_cnt_q + 1'b1 == Full) begin
              state_q <= StRun;  // full: wr_addr stays on the last word
            end else begin
              wr_addr_q <= wr_addr_q + 1'b1;
              if (load_last_i) begin
                state_q <= StRun;
              end
            end
          end else if (accept) begin
            asm_q      <= asm_word;
            byte_idx_q <= byte_idx_q + 1'b1;
          end
        end
        StRun: begin
          if (reload_i) begin
            state_q      <= StLoad;
            word_cnt_q   <= '0;
            wr_addr_q    <= '0;
            byte_idx_q   <= '0;
            asm_q        <= '0;
            inst_valid_q <= 1'b0;
            inst_out_q   <= NOP_WORD;
          end else if (!fetch_stall_i) begin
            if (fetch_req_i) begin
              inst_valid_q <= 1'b1;
              inst_addr_q  <= fetch_addr_i;
              inst_out_q   <= hit ? mem_q[fetch_addr_i] : NOP_WORD;
            end else begin
              inst_valid_q <= 1'b0;
              inst_out_q   <= NOP_WORD;
            end
          end
        end
        default: state_q <= StLoad;
      endcase
    end
  end

  assign load_ready_o = (state_q == StLoad);
  assign load_done_o  = (state_q == StRun);
  assign inst_valid_o = inst_valid_q;
  assign inst_out_o   = inst_out_q;
  assign inst_addr_o  = inst_addr_q;
  assign word_cnt_o   = word_cnt_q;

endmodule

// File: doc/inst_mem_loadable.md
Name: inst_mem_loadable

Overview:
- Parametrised, clocked instruction memory that replaces the fixed-content combinational instruction ROM in the IF stage.
- After reset, a byte-serial boot loader fills it with a program. It then serves single-cycle-latency instruction fetches to the IF stage, with a stall hold.
- Reads of addresses that were never loaded return a configurable bubble word. This keeps the pipeline safe when the PC runs off the end of the program.

Parameters:
ADDR_W, 6, word-address width; DEPTH = 2**ADDR_W words
DATA_W, 32, instruction width in bits; must be a multiple of 8; BYTES = DATA_W/8
NOP_WORD, 32'h0000_0000, value returned for unloaded addresses and when no instruction is valid

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
load_valid  in  1  loader byte valid
load_byte  in  8  loader byte, little-endian within each word
load_last  in  1  marks the final byte of the program; qualified by load_valid
load_ready  out  1  block accepts loader bytes (high only in LOAD)
load_done  out  1  high in RUN
reload  in  1  single-cycle pulse: return to LOAD and discard the loaded program
fetch_req  in  1  fetch request
fetch_addr  in  ADDR_W  word address of the requested instruction
fetch_stall  in  1  pipeline stall: hold all fetch outputs
inst_valid  out  1  inst_out and inst_addr are valid
inst_out  out  DATA_W  fetched instruction
inst_addr  out  ADDR_W  address that produced inst_out
word_cnt  out  ADDR_W+1  number of words loaded

Behaviour:
- Storage: DEPTH x DATA_W array. Contents are not cleared by reset; validity is governed only by word_cnt.
- Internal registers: state, wr_addr (ADDR_W), byte_idx (0..BYTES-1), and a word assembly register.
- Reset (async, rst_n=0):
  - state=LOAD, wr_addr=0, byte_idx=0, word_cnt=0, assembly register=0.
  - inst_valid=0, inst_out=NOP_WORD, inst_addr=0, load_ready=1, load_done=0.
- FSM, two states:
  - LOAD:
    - A byte is accepted when load_valid=1 (load_ready=1 in this state).
    - The byte goes to lane byte_idx, bits [8*byte_idx+7 : 8*byte_idx]; byte_idx then increments.
    - On the byte with byte_idx=BYTES-1, the assembled word is written to mem[wr_addr] in the same edge. Then wr_addr+1, word_cnt+1, byte_idx=0, assembly register cleared.
    - load_last on a byte with byte_idx<BYTES-1: upper lanes are zero-padded, the word is committed as above, and state goes to RUN next cycle.
    - load_last on a lane-final byte: commit, then RUN.
    - If a commit makes word_cnt==DEPTH, go to RUN regardless of load_last. No further bytes are accepted; wr_addr does not wrap.
    - load_valid=0: no change.
    - fetch_req is ignored; inst_valid stays 0.
  - RUN:
    - load_ready=0, load_done=1; loader inputs are ignored.
    - reload=1: next cycle state=LOAD, word_cnt=0, wr_addr=0, byte_idx=0, inst_valid=0, inst_out=NOP_WORD. reload takes priority over a fetch in the same cycle.
    - reload in LOAD is ignored.
- Fetch (RUN only), latency 1 cycle:
  - fetch_stall=1: inst_valid, inst_out and inst_addr hold; fetch_req is ignored and no new read is issued.
  - fetch_stall=0 and fetch_req=1: next edge sets inst_valid=1 and inst_addr=fetch_addr. inst_out = mem[fetch_addr] if fetch_addr < word_cnt, else NOP_WORD.
  - fetch_stall=0 and fetch_req=0: next edge sets inst_valid=0 and inst_out=NOP_WORD; inst_addr holds.
- Comparisons are unsigned, with fetch_addr zero-extended to ADDR_W+1 bits.
- Reset mid-load or mid-fetch discards everything (word_cnt=0). Every address then reads NOP_WORD until reloaded.

Test Plan:
- Load bytes 37,3F,00,00, E7,0F,00,02, 23,26,C0,01 (load_last on the final byte), then fetch addr 0,1,2 back-to-back -> word_cnt=3; load_done rises the cycle after the final byte; inst_out = 0x00003F37, 0x02000FE7, 0x01C02623 on consecutive cycles, with inst_valid=1 and inst_addr=0,1,2.
- Load 6 bytes 93,02,A0,02,33,03 (load_last on byte 6), then fetch addr 1 -> word_cnt=2; mem[1]=0x00000333 (zero-padded); inst_out=0x00000333.
- After the 3-word load, fetch addr 5 and addr 63 -> inst_valid=1, inst_out=NOP_WORD, inst_addr=5 then 63.
- Fetch addr 0, then raise fetch_stall for 3 cycles while fetch_req=1 and addr=2 -> inst_out stays 0x00003F37 with inst_addr=0 throughout the stall. The first edge after fetch_stall falls yields addr 2's word.
- ADDR_W=2: stream 16 bytes without load_last -> state=RUN after the 4th word, word_cnt=4, load_ready=0. A 17th byte is ignored and mem[0] is unchanged.
- Drop rst_n after 5 bytes, then release it; separately, pulse reload in RUN together with fetch_req -> both return to LOAD with word_cnt=0, inst_valid=0 and inst_out=NOP_WORD. A subsequent fetch is ignored until a load completes.
